// File: rtl/acc_pkg.sv
// Shared op encodings and saturation limits for the accumulator datapath.
package acc_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Signed min (neg = 1) or max (neg = 0) for a w-bit word, right-aligned in 32 bits.
    function automatic logic [31:0] sat_limit(input int unsigned w, input logic neg);
        logic [31:0] msb;
        msb = 32'h1 << (w - 1);
        return neg ? msb : (msb - 32'h1);
    endfunction

endpackage

// File: rtl/adder_subtractor_nbit.sv
// n-bit adder/subtractor: s = a + (b ^ {n{add_n}}) + add_n, wrapping modulo 2^n.
module adder_subtractor_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         add_n,
    output logic [n-1:0] b_eff,
    output logic [n-1:0] s
);

    assign b_eff = b ^ {n{add_n}};
    assign s     = a + b_eff + {{(n-1){1'b0}}, add_n};

endmodule

// File: rtl/accumulator_nbit.sv
// Registered accumulator with valid/ready handshakes and C/V/Z status flags.
// Optional clamp on signed overflow when ACC_SATURATE_EN is defined.
module accumulator_nbit
    import acc_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] d,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] acc,
    output logic         c_flag,
    output logic         v_flag,
    output logic         z_flag
);

    logic [n-1:0] acc_p1;
    logic         c_p1;
    logic         v_p1;
    logic         z_p1;
    logic         vld_p1;

    logic [n-1:0] y_eff;
    logic [n-1:0] sum;
    logic [n-1:0] acc_nxt;
    logic         c_nxt;
    logic         v_nxt;
    logic         z_nxt;
    logic         accept;

    assign in_ready = ~vld_p1 | out_ready;
    assign accept   = in_valid & in_ready;

    adder_subtractor_nbit #(.n(n)) u_addsub (
        .a     (acc_p1),
        .b     (d),
        .add_n (op == OP_SUB),
        .b_eff (y_eff),
        .s     (sum)
    );

    // Stage p0: next accumulator value and flags from the current op
    always_comb begin
        acc_nxt = '0;
        c_nxt   = 1'b0;
        v_nxt   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                acc_nxt = sum;
                c_nxt   = (acc_p1[n-1] & y_eff[n-1]) | ((acc_p1[n-1] ^ y_eff[n-1]) & ~sum[n-1]);
                v_nxt   = (acc_p1[n-1] == y_eff[n-1]) & (sum[n-1] != acc_p1[n-1]);
`ifdef ACC_SATURATE_EN
                if (v_nxt) begin
                    acc_nxt = n'(sat_limit(n, acc_p1[n-1]));
                end
`endif
            end
            OP_LOAD: acc_nxt = d;
            default: acc_nxt = '0;
        endcase
        z_nxt = (acc_nxt == '0);
    end

    // Stage p1: result register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_p1 <= '0;
            c_p1   <= 1'b0;
            v_p1   <= 1'b0;
            z_p1   <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (accept) begin
            acc_p1 <= acc_nxt;
            c_p1   <= c_nxt;
            v_p1   <= v_nxt;
            z_p1   <= z_nxt;
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign acc       = acc_p1;
    assign c_flag    = c_p1;
    assign v_flag    = v_p1;
    assign z_flag    = z_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_accumulator_nbit.sv
// Directed self-checking bench for accumulator_nbit (n = 4).
// Define ACC_SATURATE_EN for both DUT and bench to check the clamping build.
module tb_accumulator_nbit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] d;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       c_flag;
    logic       v_flag;
    logic       z_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // {acc, c, v, z, out_valid, in_ready}
    logic [8:0] st;
    assign st = {acc, c_flag, v_flag, z_flag, out_valid, in_ready};

    accumulator_nbit #(.n(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .c_flag    (c_flag),
        .v_flag    (v_flag),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    // One accepted operation: drive at negedge, release just after the edge.
    task automatic send(input logic [1:0] o, input logic [3:0] v);
        @(negedge clk);
        op = o; d = v; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; op = 2'b10; d = 4'h5; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (st !== {4'h0, 5'b00001}) begin
            n_fail++; $display("FAIL reset_state: got %b want %b", st, {4'h0, 5'b00001});
        end
        @(negedge clk);
        in_valid = 1'b0; reset_n = 1'b1;
        idle();
        n_checks++;
        if (st !== {4'h0, 5'b00001}) begin
            n_fail++; $display("FAIL reset_nothing_accepted: got %b want %b", st, {4'h0, 5'b00001});
        end
    endtask

    task automatic test_add_overflow();
        send(2'b10, 4'h7);
        n_checks++;
        if (st !== {4'h7, 5'b00011}) begin
            n_fail++; $display("FAIL load7: got %b want %b", st, {4'h7, 5'b00011});
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL retire_drop: got %b want 0", out_valid);
        end
        send(2'b00, 4'h5);
`ifdef ACC_SATURATE_EN
        n_checks++;
        if (st !== {4'h7, 5'b01011}) begin
            n_fail++; $display("FAIL add_7_5_sat: got %b want %b", st, {4'h7, 5'b01011});
        end
`else
        n_checks++;
        if (st !== {4'hC, 5'b01011}) begin
            n_fail++; $display("FAIL add_7_5: got %b want %b", st, {4'hC, 5'b01011});
        end
`endif
        idle();
    endtask

    task automatic test_carry_and_zero();
        send(2'b10, 4'h9);
        send(2'b00, 4'h8);
`ifdef ACC_SATURATE_EN
        n_checks++;
        if (st !== {4'h8, 5'b11011}) begin
            n_fail++; $display("FAIL add_9_8_sat: got %b want %b", st, {4'h8, 5'b11011});
        end
`else
        n_checks++;
        if (st !== {4'h1, 5'b11011}) begin
            n_fail++; $display("FAIL add_9_8: got %b want %b", st, {4'h1, 5'b11011});
        end
`endif
        send(2'b10, 4'h3);
        send(2'b01, 4'h3);
        n_checks++;
        if (st !== {4'h0, 5'b10111}) begin
            n_fail++; $display("FAIL sub_3_3: got %b want %b", st, {4'h0, 5'b10111});
        end
        send(2'b10, 4'h0);
        n_checks++;
        if (st !== {4'h0, 5'b00111}) begin
            n_fail++; $display("FAIL load0_z: got %b want %b", st, {4'h0, 5'b00111});
        end
        send(2'b01, 4'h0);
        n_checks++;
        if (st !== {4'h0, 5'b10111}) begin
            n_fail++; $display("FAIL sub_0_0: got %b want %b", st, {4'h0, 5'b10111});
        end
        idle();
    endtask

    task automatic test_sub_clear();
        send(2'b10, 4'h2);
        send(2'b01, 4'h5);
        n_checks++;
        if (st !== {4'hD, 5'b00011}) begin
            n_fail++; $display("FAIL sub_2_5: got %b want %b", st, {4'hD, 5'b00011});
        end
        send(2'b11, 4'hA);
        n_checks++;
        if (st !== {4'h0, 5'b00111}) begin
            n_fail++; $display("FAIL clear: got %b want %b", st, {4'h0, 5'b00111});
        end
        send(2'b10, 4'h8);
        send(2'b01, 4'h1);
`ifdef ACC_SATURATE_EN
        n_checks++;
        if (st !== {4'h8, 5'b11011}) begin
            n_fail++; $display("FAIL sub_8_1_sat: got %b want %b", st, {4'h8, 5'b11011});
        end
`else
        n_checks++;
        if (st !== {4'h7, 5'b11011}) begin
            n_fail++; $display("FAIL sub_8_1: got %b want %b", st, {4'h7, 5'b11011});
        end
`endif
        idle();
        idle();
        n_checks++;
        if (st[8:2] !== st[8:2] || acc !== (4'h7 ^ {4{1'b0}}) && acc !== 4'h8) begin
            n_fail++; $display("FAIL idle_hold: got %h want 7 or 8", acc);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(2'b10, 4'h1);
        @(negedge clk);
        op = 2'b00; d = 4'h2; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (st !== {4'h1, 5'b00010}) begin
                n_fail++; $display("FAIL stall_%0d: got %b want %b", i, st, {4'h1, 5'b00010});
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_comb: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++;
        if (st !== {4'h3, 5'b00011}) begin
            n_fail++; $display("FAIL b2b_result: got %b want %b", st, {4'h3, 5'b00011});
        end
        idle();
        n_checks++;
        if (st !== {4'h3, 5'b00001}) begin
            n_fail++; $display("FAIL b2b_retire: got %b want %b", st, {4'h3, 5'b00001});
        end
    endtask

    task automatic test_reset_mid_handshake();
        out_ready = 1'b0;
        send(2'b10, 4'h6);
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b1; op = 2'b00; d = 4'h1;
        @(posedge clk);
        #1;
        n_checks++;
        if (st !== {4'h0, 5'b00001}) begin
            n_fail++; $display("FAIL reset_mid: got %b want %b", st, {4'h0, 5'b00001});
        end
        @(negedge clk);
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        idle();
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; d = '0; op = '0; out_ready = 1'b1;
        test_reset();
        test_add_overflow();
        test_carry_and_zero();
        test_sub_clear();
        test_back_to_back();
        test_reset_mid_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
